// File: rtl/alu_control_mc.sv
// Registered, handshaked ALU control decoder. It decodes ALUOp/func into an ALU control code
// and sequences multi-cycle MULT/DIV operations by holding issue stalled for a fixed latency.
module alu_control_mc #(
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned FUNC_W      = 6,
    parameter int unsigned CTRL_W      = 4,
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNC_W-1:0]  func,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_cntrl,
    output logic               illegal,
    output logic               md_start,
    output logic               stall
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StMdWait} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      dec_code;
    logic            dec_illegal;
    logic            func_hi_zero;
    logic            accept;
    logic            is_mult;
    logic            is_div;

    assign func_hi_zero = ((func >> 6) == '0);

    always_comb begin
        dec_code    = 4'd12;
        dec_illegal = 1'b1;
        if (alu_op == ALUOP_W'(0)) begin
            dec_code    = 4'd2;
            dec_illegal = 1'b0;
        end else if (alu_op == ALUOP_W'(1)) begin
            dec_code    = 4'd6;
            dec_illegal = 1'b0;
        end else if (alu_op == ALUOP_W'(3)) begin
            dec_code    = 4'd1;
            dec_illegal = 1'b0;
        end else if (alu_op == ALUOP_W'(2) && func_hi_zero) begin
            dec_illegal = 1'b0;
            case (func[5:0])
                6'b100100: dec_code = 4'd0;
                6'b100101: dec_code = 4'd1;
                6'b100000,
                6'b100001: dec_code = 4'd2;
                6'b100111: dec_code = 4'd3;
                6'b100110: dec_code = 4'd4;
                6'b000010: dec_code = 4'd5;
                6'b100010,
                6'b100011: dec_code = 4'd6;
                6'b101010: dec_code = 4'd7;
                6'b101011: dec_code = 4'd8;
                6'b011000: dec_code = 4'd9;
                6'b011001: dec_code = 4'd10;
                6'b000000: dec_code = 4'd11;
                6'b011011: dec_code = 4'd13;
                6'b011010: dec_code = 4'd14;
                6'b000011: dec_code = 4'd15;
                default: begin
                    dec_code    = 4'd12;
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    assign is_mult = (dec_code == 4'd9) || (dec_code == 4'd10);
    assign is_div  = (dec_code == 4'd13) || (dec_code == 4'd14);

    // Flush blocks acceptance so an op offered alongside it is never half-taken.
    assign in_ready = !flush && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
    assign stall    = !in_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            alu_cntrl <= '0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            md_start  <= 1'b0;
        end else if (flush) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            md_start  <= 1'b0;
        end else begin
            md_start <= 1'b0;
            case (state_q)
                StIdle, StHold: begin
                    if (accept) begin
                        alu_cntrl <= CTRL_W'(dec_code);
                        illegal   <= dec_illegal;
                        if (is_mult || is_div) begin
                            cnt_q     <= is_mult ? MultLoad : DivLoad;
                            state_q   <= StMdWait;
                            out_valid <= 1'b0;
                            md_start  <= 1'b1;
                        end else begin
                            state_q   <= StHold;
                            out_valid <= 1'b1;
                        end
                    end else if (state_q == StHold && out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                StMdWait: begin
                    if (cnt_q == '0) begin
                        state_q   <= StHold;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed self-checking bench for alu_control_mc with default parameters
// (MULT_CYCLES=4, DIV_CYCLES=16).
module tb_alu_control_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] func;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_cntrl;
    logic       illegal;
    logic       md_start;
    logic       stall;

    int errors = 0;
    int checks = 0;

    alu_control_mc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func      (func),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_cntrl (alu_cntrl),
        .illegal   (illegal),
        .md_start  (md_start),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one active edge, then settle so registered outputs can be sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [1:0] op, input logic [5:0] f);
        in_valid = v;
        alu_op   = op;
        func     = f;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'd0; func = 6'd0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_cntrl", alu_cntrl, 0);
        check("rst_illegal", illegal, 0);
        check("rst_md_start", md_start, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back R-type: AND, SLTU, SRA
        offer(1, 2'd2, 6'b100100);
        check("b2b_ready0", in_ready, 1);
        step();
        check("b2b_and", alu_cntrl, 0);
        check("b2b_and_v", out_valid, 1);
        offer(1, 2'd2, 6'b101011);
        check("b2b_ready1", in_ready, 1);
        step();
        check("b2b_sltu", alu_cntrl, 8);
        offer(1, 2'd2, 6'b000011);
        check("b2b_ready2", in_ready, 1);
        step();
        check("b2b_sra", alu_cntrl, 15);
        check("b2b_sra_v", out_valid, 1);
        offer(0, 2'd0, 6'd0);
        step();
        check("b2b_idle_v", out_valid, 0);

        // Illegal func and non-R ALUOps
        offer(1, 2'd2, 6'b111111);
        step();
        check("ill_code", alu_cntrl, 12);
        check("ill_flag", illegal, 1);
        offer(1, 2'd0, 6'b111111);
        step();
        check("op0_code", alu_cntrl, 2);
        check("op0_ill", illegal, 0);
        offer(1, 2'd1, 6'b011010);
        step();
        check("op1_code", alu_cntrl, 6);
        offer(1, 2'd3, 6'b000000);
        step();
        check("op3_code", alu_cntrl, 1);
        offer(1, 2'd2, 6'b000010);
        step();
        check("srl_code", alu_cntrl, 5);
        offer(0, 2'd0, 6'd0);
        step();

        // Backpressure: ADD held, SUB waits
        out_ready = 1'b0;
        offer(1, 2'd2, 6'b100000);
        step();
        check("bp_add", alu_cntrl, 2);
        offer(1, 2'd2, 6'b100010);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", in_ready, 0);
            step();
            check("bp_hold_code", alu_cntrl, 2);
            check("bp_hold_v", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        check("bp_sub", alu_cntrl, 6);
        check("bp_sub_v", out_valid, 1);
        offer(0, 2'd0, 6'd0);
        step();

        // DIV: 16-cycle stall, next op taken only once the result is consumed
        offer(1, 2'd2, 6'b011010);
        check("div_ready", in_ready, 1);
        step();
        check("div_md_start", md_start, 1);
        check("div_v0", out_valid, 0);
        check("div_stall0", in_ready, 0);
        offer(1, 2'd2, 6'b100100);
        for (int k = 1; k < 16; k++) begin
            step();
            check("div_md_low", md_start, 0);
            check("div_wait_v", out_valid, 0);
            check("div_wait_ready", in_ready, 0);
        end
        step();
        check("div_done_v", out_valid, 1);
        check("div_done_code", alu_cntrl, 14);
        check("div_done_ready", in_ready, 1);
        step();
        check("div_next_code", alu_cntrl, 0);
        check("div_next_v", out_valid, 1);
        offer(0, 2'd0, 6'd0);
        step();

        // MULTU: result after 4 cycles
        offer(1, 2'd2, 6'b011001);
        step();
        offer(0, 2'd0, 6'd0);
        check("multu_md_start", md_start, 1);
        for (int k = 1; k < 4; k++) begin
            step();
            check("multu_wait_v", out_valid, 0);
        end
        step();
        check("multu_v", out_valid, 1);
        check("multu_code", alu_cntrl, 10);
        step();

        // Flush during MULT wait (counter at 2), with an op offered alongside
        offer(1, 2'd2, 6'b011000);
        step();
        offer(0, 2'd0, 6'd0);
        step();
        flush = 1'b1;
        offer(1, 2'd2, 6'b100100);
        check("flush_ready", in_ready, 0);
        check("flush_stall", stall, 1);
        step();
        flush = 1'b0;
        offer(0, 2'd0, 6'd0);
        check("flush_v", out_valid, 0);
        check("flush_idle_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("flush_never_v", out_valid, 0);
        end
        flush = 1'b1;
        offer(1, 2'd2, 6'b100101);
        check("flush_idle_block", in_ready, 0);
        step();
        flush = 1'b0;
        offer(0, 2'd0, 6'd0);
        check("flush_idle_v", out_valid, 0);

        // Asynchronous reset mid MD_WAIT
        offer(1, 2'd2, 6'b011000);
        step();
        offer(0, 2'd0, 6'd0);
        step();
        rst_n = 1'b0;
        #1;
        check("arst_v", out_valid, 0);
        check("arst_ready", in_ready, 1);
        check("arst_md", md_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("arst_no_md", md_start, 0);
            check("arst_no_v", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
Registered, handshaked successor to the combinational ALU control decoder. It decodes ALUOp/Func into an ALU control code and extends the R-type set with unsigned, SLTU, and shift operations. It sequences multi-cycle MULT/DIV operations by launching the mul/div unit and holding the issue stage stalled for a parametrised latency. It sits between ID/EX issue logic and the ALU/MDU.

Parameters:
ALUOP_W, 2, ALUOp width (values above 3 decode as illegal)
FUNC_W, 6, function-field width (upper bits above 6 must be zero for a legal R-type)
CTRL_W, 4, control-code width (>=4; codes zero-extended)
MULT_CYCLES, 4, MULT/MULTU latency in cycles (>=1)
DIV_CYCLES, 16, DIV/DIVU latency in cycles (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  issue offers an op
in_ready  out  1  block accepts op this cycle
alu_op  in  ALUOP_W  ALUOp from main control
func  in  FUNC_W  instruction function field
flush  in  1  synchronous pipeline flush
out_valid  out  1  alu_cntrl valid for EX
out_ready  in  1  EX consumes result
alu_cntrl  out  CTRL_W  registered control code
illegal  out  1  registered: unknown func/ALUOp (code 12)
md_start  out  1  one-cycle pulse launching MDU
stall  out  1  equals !in_ready

Behaviour:
- Reset (async, rst_n=0): state=IDLE, alu_cntrl=0, out_valid=0, illegal=0, md_start=0, counter=0. Consequently in_ready=1 and stall=0 once reset is released.
- Decode (combinational, internal):
  - ALUOp 0 -> 2; 1 -> 6; 3 -> 1 (ORI).
  - ALUOp 2 uses func: 100100->0 AND; 100101->1 OR; 100000/100001->2 ADD/ADDU; 100111->3 NOR; 100110->4 XOR; 000010->5 SRL; 100010/100011->6 SUB/SUBU; 101010->7 SLT; 101011->8 SLTU; 011000->9 MULT; 011001->10 MULTU; 000000->11 SLL; 011011->13 DIVU; 011010->14 DIV; 000011->15 SRA.
  - Any other func -> 12 with illegal=1.
- States:
  - IDLE: no output held.
  - HOLD: output valid, waiting for out_ready.
  - MD_WAIT: MDU running.
- in_ready = (IDLE) | (HOLD & out_ready). Back-to-back single-cycle ops sustain 1/cycle.
- Accept (in_valid & in_ready at edge T):
  - alu_cntrl and illegal are registered.
  - Single-cycle code: go to HOLD; out_valid=1 from T.
  - Codes 9/10: load counter=MULT_CYCLES-1, go to MD_WAIT, md_start=1 for the cycle after T only, out_valid=0.
  - Codes 13/14: same, with counter=DIV_CYCLES-1.
- MD_WAIT: counter decrements each cycle.
  - When counter==0: go to HOLD, out_valid=1.
  - out_valid therefore rises after edge T+N, where N is the latency.
  - in_ready=0 throughout MD_WAIT.
- HOLD & out_ready & !in_valid: go to IDLE; out_valid=0.
- HOLD & !out_ready: alu_cntrl, illegal, and out_valid stay stable (no change while stalled).
- flush (sync, highest priority after reset):
  - Go to IDLE; out_valid=0, md_start=0, counter=0.
  - Any op offered in the same cycle is not accepted (in_ready is forced 0 while flush=1).
  - alu_cntrl retains its last value (don't-care).
- rst_n asserted mid-MD_WAIT: immediate return to reset values; no md_start follows release.
- Latency-1 corner (MULT_CYCLES=1): MD_WAIT lasts one cycle; md_start and the HOLD transition happen on consecutive edges.

Test Plan:
- Reset mid-op: rst_n low during MD_WAIT -> out_valid=0, in_ready=1 asynchronously; no md_start after release.
- Back-to-back R-type: AND (alu_op=2, func=100100), then SLTU (101011), then SRA (000011), out_ready=1 -> alu_cntrl 0, 8, 15 on consecutive cycles, in_ready held 1.
- DIV with DIV_CYCLES=16: func=011010 accepted at T:
  - md_start=1 for one cycle.
  - in_ready=0 for 16 cycles.
  - out_valid rises after edge T+16 with alu_cntrl=14.
  - A second op held on in_valid is accepted only when the DIV result is consumed.
- Backpressure: ADD accepted, out_ready=0 for 5 cycles -> alu_cntrl=2 and out_valid=1 stable, in_ready=0. Then out_ready=1 with a new SUB waiting -> next alu_cntrl=6.
- Illegal/other ALUOp: alu_op=2, func=111111 -> alu_cntrl=12, illegal=1. alu_op=0 and alu_op=1 -> 2 and 6, with func ignored.
- Flush: flush during MULT MD_WAIT (counter=2) -> next cycle IDLE, out_valid never asserts for that MULT. A flush coinciding with in_valid accepts nothing.
